// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame controller: start detect, oversampled bit voting, LSB-first deserialize, parity/stop check.
// Optional 3-sample majority vote enabled by defining UART_RX_MAJORITY_VOTE_EN (single mid-bit sample otherwise).
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  cnt_enable
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] DCNT_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                state_q, state_d;
  logic [5:0]            ecnt_q, ecnt_d;
  logic [5:0]            prescale_q, prescale_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  vote_q, vote_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic [CW-1:0]         dcnt_q, dcnt_d;
  logic                  frame_err_q, frame_err_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  cnt_enable_q, cnt_enable_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
  logic                  samp_a_q, samp_a_d;
  logic                  samp_b_q, samp_b_d;
`endif

  logic [5:0] mid;
  logic [5:0] last;
  logic       bit_end;
  logic       sampling;

  assign mid      = prescale_q >> 1;
  assign last     = prescale_q - 6'd1;
  assign bit_end  = (ecnt_q == last);
  assign sampling = (state_q != S_IDLE);

  // Bit value is settled well before bit end, so the FSM only ever consumes vote_q.
  always_comb begin
    vote_d = vote_q;
`ifdef UART_RX_MAJORITY_VOTE_EN
    samp_a_d = samp_a_q;
    samp_b_d = samp_b_q;
    if (sampling) begin
      if (ecnt_q == mid - 6'd1) samp_a_d = RX_IN;
      if (ecnt_q == mid)        samp_b_d = RX_IN;
      if (ecnt_q == mid + 6'd1)
        vote_d = (samp_a_q & samp_b_q) | (samp_a_q & RX_IN) | (samp_b_q & RX_IN);
    end
`else
    if (sampling && (ecnt_q == mid)) vote_d = RX_IN;
`endif
  end

  always_comb begin
    state_d      = state_q;
    ecnt_d       = bit_end ? 6'd0 : ecnt_q + 6'd1;
    prescale_d   = prescale_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    shift_d      = shift_q;
    p_data_d     = p_data_q;
    dcnt_d       = dcnt_q;
    frame_err_d  = frame_err_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        ecnt_d = 6'd0;
        if (!RX_IN) begin
          // Detection cycle is edge 0 of the start bit.
          state_d    = S_START;
          ecnt_d     = 6'd1;
          prescale_d = (Prescale < 6'd8) ? 6'd8 : Prescale;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
        end
      end
      S_START: begin
        if (bit_end) begin
          if (vote_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            dcnt_d  = '0;
          end
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {vote_q, shift_q[DATA_WIDTH-1:1]};
          dcnt_d  = dcnt_q + 1'b1;
          if (dcnt_q == DCNT_LAST) state_d = par_en_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          if (vote_q != (par_typ_q ? ~^shift_q : ^shift_q)) begin
            frame_err_d = 1'b1;
            par_err_d   = 1'b1;
          end
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (!vote_q) begin
            stp_err_d = 1'b1;
          end else if (!frame_err_q) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
          frame_err_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        ecnt_d  = 6'd0;
      end
    endcase

    cnt_enable_d = (state_d == S_DATA);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      ecnt_q       <= 6'd0;
      prescale_q   <= 6'd8;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      vote_q       <= 1'b0;
      shift_q      <= '0;
      p_data_q     <= '0;
      dcnt_q       <= '0;
      frame_err_q  <= 1'b0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      cnt_enable_q <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
      samp_a_q     <= 1'b0;
      samp_b_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ecnt_q       <= ecnt_d;
      prescale_q   <= prescale_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      vote_q       <= vote_d;
      shift_q      <= shift_d;
      p_data_q     <= p_data_d;
      dcnt_q       <= dcnt_d;
      frame_err_q  <= frame_err_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      cnt_enable_q <= cnt_enable_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
      samp_a_q     <= samp_a_d;
      samp_b_q     <= samp_b_d;
`endif
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;
  assign cnt_enable = cnt_enable_q;

endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Receive-side frame controller for the UART RX path. It detects the start bit on the serial line and oversamples each bit at the Prescale rate. It votes on each bit value, deserializes 8 data bits LSB-first, and checks the optional parity bit and the stop bit. It sits between the RX_IN pad input and the RX data-sync/register-file path. It also drives the `enable` input of the RX edge/bit counter during the data phase.

## Interface
Parameters:
- DATA_WIDTH, 8, number of data bits per frame (fixed at 8 for this design).

Ports:
- CLK  input  1  receive oversampling clock.
- RST  input  1  reset, synchronous, active-low.
- RX_IN  input  1  serial line, idle high; already synchronized upstream.
- Prescale  input  6  oversampling ratio, in edges per bit.
- PAR_EN  input  1  1 = parity bit present.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- P_DATA  output  8  last good received byte.
- data_valid  output  1  1-cycle pulse when P_DATA is updated.
- par_err  output  1  1-cycle pulse on parity mismatch.
- stp_err  output  1  1-cycle pulse on a bad stop bit.
- cnt_enable  output  1  high while in DATA state; drives the edge/bit counter's `enable`.

## Operation
- Configuration latch: Prescale, PAR_EN and PAR_TYP are latched on the IDLE→START transition and held for the whole frame.
  - A latched Prescale below 8 is clamped to 8.
  - Let M = floor(P/2).
- Edge counter: internal ecnt counts 0..P-1 within each bit and wraps to 0 at P-1 (bit end).
- Bit vote: RX_IN is sampled at ecnt = M-1, M and M+1. The bit value is the 2-of-3 majority, registered at ecnt = M+1.
- IDLE:
  - ecnt is held at 0.
  - RX_IN==0 → START with ecnt<=1; the detection cycle counts as edge 0.
- START: at bit end, a voted bit of 1 is a glitch → IDLE with no outputs. A voted bit of 0 → DATA.
- DATA:
  - At each bit end, the voted bit is shifted into the shift register MSB-side, giving LSB-first order.
  - An internal 3-bit data counter advances.
  - After the 8th bit → PARITY if PAR_EN, else STOP.
- PARITY:
  - Expected bit = ^shift for even parity, ~^shift for odd parity.
  - On mismatch, an internal frame-error flag is set and par_err pulses in the cycle after bit end.
  - → STOP.
- STOP:
  - At bit end, a voted bit of 0 pulses stp_err.
  - If there is no stop error and no frame-error flag: P_DATA <= shift and data_valid pulses.
  - → IDLE. The frame-error flag is cleared.
- P_DATA holds its value until the next good frame. Errored frames never modify it.
- par_err and stp_err may both fire in one frame, in different cycles.

## Timing
- Reset (RST==0 at a CLK edge) gives the following values on that edge:
  - state = IDLE
  - P_DATA = 8'h00
  - data_valid, par_err, stp_err and cnt_enable = 0
  - ecnt, the shift register and all flags = 0
- Reset mid-frame aborts the frame with no pulses.
- All outputs are registered.
- data_valid and stp_err assert in the cycle after the stop bit's ecnt = P-1 edge. par_err behaves the same relative to the parity bit.
- Frame length from the detection edge to the data_valid edge:
  - P×10 cycles without parity.
  - P×11 cycles with parity.
- Back-to-back frames: IDLE is re-entered in the data_valid cycle. A start bit whose falling edge lands in that cycle is detected in that same cycle.
- cnt_enable is high from the DATA entry cycle through the last DATA cycle, inclusive.

## Configuration
- UART_RX_MAJORITY_VOTE_EN defined: 3-sample majority vote as described above.
- UART_RX_MAJORITY_VOTE_EN undefined:
  - The bit value is a single sample at ecnt = M, registered at ecnt = M.
  - All other timing is unchanged.

## Test plan
- No-parity frame: Prescale=8, PAR_EN=0, send 0xA5 → one data_valid pulse 80 cycles after the start edge, P_DATA=8'hA5, par_err=stp_err=0, cnt_enable high for 64 cycles.
- Even-parity frame: Prescale=16, PAR_EN=1, PAR_TYP=0.
  - Send 0x3C with parity bit 0 → data_valid, P_DATA=8'h3C.
  - Resend with parity bit 1 → par_err pulses once, no data_valid, P_DATA stays 8'h3C.
- Bad stop bit: Prescale=8, send 0x81 with stop bit 0 → stp_err pulse, no data_valid, P_DATA unchanged.
- Start glitch and config latch:
  - RX_IN low for 2 cycles at Prescale=16 → return to IDLE, no pulses.
  - Change Prescale mid-frame → the frame still decodes at the latched rate.
- Vote robustness: invert RX_IN for one cycle at ecnt=M of data bit 3.
  - With the macro defined, the byte is received correctly.
  - Without the macro, bit 3 is flipped in P_DATA.
- Reset mid-frame: assert RST during DATA bit 4 → all outputs 0 and IDLE next edge; the following 0x5A frame is received correctly.
